// File: rtl/s8_bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package s8_bit_serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/s8_bit_serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   always_comb begin
      d    = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
   end

endmodule

// File: rtl/s8_bit_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first,
// sharing one full_subtractor cell; start/ready/done handshake.
module s8_bit_serial_subtractor
   import s8_bit_serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero,
   output logic             overflow
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sh_a_q, sh_a_d;
   logic [WIDTH-1:0]   sh_b_q, sh_b_d;
   logic [WIDTH-1:0]   diff_sh_q, diff_sh_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               bw_q, bw_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_out_q, borrow_out_d;
   logic               zero_q, zero_d;
   logic               overflow_q, overflow_d;
   logic               fs_d, fs_bout;

   full_subtractor u_fs (
      .x    (sh_a_q[0]),
      .y    (sh_b_q[0]),
      .bin  (bw_q),
      .d    (fs_d),
      .bout (fs_bout)
   );

   always_comb begin
      state_d      = state_q;
      sh_a_d       = sh_a_q;
      sh_b_d       = sh_b_q;
      diff_sh_d    = diff_sh_q;
      cnt_d        = cnt_q;
      bw_d         = bw_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;
      zero_d       = zero_q;
      overflow_d   = overflow_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sh_a_d    = a;
               sh_b_d    = b;
               bw_d      = borrow_in;
               cnt_d     = '0;
               diff_sh_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sh_a_d    = sh_a_q >> 1;
            sh_b_d    = sh_b_q >> 1;
            diff_sh_d = {fs_d, diff_sh_q[WIDTH-1:1]};
            bw_d      = fs_bout;
            // On the MSB, bw_q is the borrow into the MSB, so overflow compares it with the borrow out.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               overflow_d   = bw_q ^ fs_bout;
               diff_d       = diff_sh_d;
               borrow_out_d = fs_bout;
               zero_d       = (diff_sh_d == '0);
               state_d      = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sh_a_q       <= '0;
         sh_b_q       <= '0;
         diff_sh_q    <= '0;
         cnt_q        <= '0;
         bw_q         <= 1'b0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         zero_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sh_a_q       <= sh_a_d;
         sh_b_q       <= sh_b_d;
         diff_sh_q    <= diff_sh_d;
         cnt_q        <= cnt_d;
         bw_q         <= bw_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
         zero_q       <= zero_d;
         overflow_q   <= overflow_d;
      end
   end

   always_comb begin
      ready      = (state_q == S_IDLE);
      done       = (state_q == S_DONE);
      diff       = diff_q;
      borrow_out = borrow_out_q;
      zero       = zero_q;
      overflow   = overflow_q;
   end

endmodule

// File: tb/tb_s8_bit_serial_subtractor.sv
// Self-checking bench for s8_bit_serial_subtractor: directed plan cases plus
// randomized operands compared against an arithmetic reference model.
module tb_s8_bit_serial_subtractor;
   import s8_bit_serial_subtractor_pkg::*;

   localparam int W = DEFAULT_WIDTH;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         borrow_in = 1'b0;
   logic         ready, done, borrow_out, zero, overflow;
   logic [W-1:0] diff;

   int total = 0;
   int bad   = 0;

   s8_bit_serial_subtractor #(.WIDTH(W), .CNT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .ready      (ready),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .zero       (zero),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Reference: plain integer subtraction; packed as {overflow, zero, borrow_out, diff}.
   function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mbin);
      int ua, sa;
      logic [W-1:0] r;
      ua = int'(ma) - int'(mb) - int'(mbin);
      sa = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      r  = W'(ua);
      return {(sa < -(1 << (W-1))) || (sa > (1 << (W-1)) - 1), r == '0, ua < 0, r};
   endfunction

   // Drives a one-cycle start; returns at the falling edge after the accepting edge.
   task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
      @(negedge clk);
      a = va; b = vb; borrow_in = vbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits (bounded) for done; cycles = -1 on timeout, ready_seen flags ready=1 while busy.
   task automatic wait_done(output int cycles, output bit ready_seen);
      cycles = 0;
      ready_seen = 1'b0;
      while (done !== 1'b1) begin
         if (ready !== 1'b0) ready_seen = 1'b1;
         if (cycles > 40) begin
            cycles = -1;
            return;
         end
         @(negedge clk);
         cycles++;
      end
      if (ready !== 1'b0) ready_seen = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({ready, done, diff, borrow_out, zero, overflow} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
         bad++;
         $display("[TB] FAIL reset_state got rdy=%b done=%b diff=%h bo=%b z=%b ov=%b want 1 0 00 0 0 0",
                  ready, done, diff, borrow_out, zero, overflow);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Runs one operation and checks latency, busy ready, results and the single-cycle done.
   task automatic run_and_check(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vbin);
      int cyc;
      bit rs;
      logic [W+2:0] exp;
      exp = model(va, vb, vbin);
      start_op(va, vb, vbin);
      wait_done(cyc, rs);
      total++;
      if (cyc !== 8) begin
         bad++;
         $display("[TB] FAIL %s_latency got %0d want 8", name, cyc);
      end
      total++;
      if (rs) begin
         bad++;
         $display("[TB] FAIL %s_busy_ready got ready=1 while busy want 0", name);
      end
      total++;
      if ({overflow, zero, borrow_out, diff} !== exp) begin
         bad++;
         $display("[TB] FAIL %s_result got ov=%b z=%b bo=%b diff=%h want ov=%b z=%b bo=%b diff=%h",
                  name, overflow, zero, borrow_out, diff, exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
      end
      @(negedge clk);
      total++;
      if ({ready, done} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL %s_after_done got rdy=%b done=%b want rdy=1 done=0", name, ready, done);
      end
   endtask

   task automatic test_directed;
      run_and_check("sub_35_12", 8'h35, 8'h12, 1'b0);
      run_and_check("sub_12_35", 8'h12, 8'h35, 1'b0);
      run_and_check("sub_00_00_b", 8'h00, 8'h00, 1'b1);
      run_and_check("ovf_80_01", 8'h80, 8'h01, 1'b0);
      run_and_check("ovf_7f_ff", 8'h7F, 8'hFF, 1'b0);
   endtask

   task automatic test_zero_hold;
      int cyc;
      bit held_bad;
      run_and_check("zero_05_05", 8'h05, 8'h05, 1'b0);
      start_op(8'h06, 8'h05, 1'b0);
      held_bad = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (diff !== 8'h00 || zero !== 1'b1) held_bad = 1'b1;
         @(negedge clk);
         cyc++;
      end
      total++;
      if (held_bad || cyc !== 8) begin
         bad++;
         $display("[TB] FAIL zero_hold got held_bad=%b cycles=%0d want held_bad=0 cycles=8", held_bad, cyc);
      end
      total++;
      if ({diff, zero} !== {8'h01, 1'b0}) begin
         bad++;
         $display("[TB] FAIL zero_next got diff=%h z=%b want diff=01 z=0", diff, zero);
      end
      @(negedge clk);
   endtask

   task automatic test_ignored_start;
      int cyc;
      bit rs;
      logic [W+2:0] exp;
      exp = model(8'hA7, 8'h3C, 1'b1);
      start_op(8'hA7, 8'h3C, 1'b1);
      @(negedge clk);
      a = 8'h11; b = 8'hEE; borrow_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, rs);
      total++;
      if (cyc !== 6 || {overflow, zero, borrow_out, diff} !== exp) begin
         bad++;
         $display("[TB] FAIL ignored_start got cyc=%0d res=%h want cyc=6 res=%h", cyc,
                  {overflow, zero, borrow_out, diff}, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int seen;
      start_op(8'hC3, 8'h5A, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({ready, done, diff, borrow_out, zero, overflow} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
         bad++;
         $display("[TB] FAIL reset_mid got rdy=%b done=%b diff=%h bo=%b z=%b ov=%b want 1 0 00 0 0 0",
                  ready, done, diff, borrow_out, zero, overflow);
      end
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("[TB] FAIL reset_mid_no_done got %0d done pulses want 0", seen);
      end
      rst = 1'b1; start = 1'b1; a = 8'h44; b = 8'h22;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      seen = 0;
      repeat (12) begin
         if (done === 1'b1 || ready !== 1'b1) seen++;
         @(negedge clk);
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("[TB] FAIL rst_wins_start got %0d busy/done cycles want 0", seen);
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      bit rs;
      logic [W+2:0] exp_a, exp_b;
      exp_a = model(8'h9C, 8'h47, 1'b0);
      exp_b = model(8'h21, 8'hD0, 1'b1);
      start_op(8'h9C, 8'h47, 1'b0);
      wait_done(cyc, rs);
      total++;
      if ({overflow, zero, borrow_out, diff} !== exp_a) begin
         bad++;
         $display("[TB] FAIL b2b_first got %h want %h", {overflow, zero, borrow_out, diff}, exp_a);
      end
      start_op(8'h21, 8'hD0, 1'b1);
      wait_done(cyc, rs);
      total++;
      if (cyc !== 8 || {overflow, zero, borrow_out, diff} !== exp_b) begin
         bad++;
         $display("[TB] FAIL b2b_second got gap=%0d res=%h want gap=10 res=%h", cyc + 2,
                  {overflow, zero, borrow_out, diff}, exp_b);
      end
      @(negedge clk);
   endtask

   task automatic test_random;
      logic [W-1:0] ra, rb;
      logic rbin;
      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rbin = 1'($urandom_range(0, 1));
         run_and_check($sformatf("rand%0d", i), ra, rb, rbin);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_zero_hold;
      test_ignored_start;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
